// File: rtl/scale_pkg.sv
// Shared types and width helpers for the power-of-two image down-scaler.
package scale_pkg;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  function automatic int sum_w(input int pix_w, input int f_log2);
    return pix_w + 2 * f_log2;
  endfunction

  function automatic int buf_depth(input int img_w, input int f_log2);
    return img_w >> f_log2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scale_line_buf.sv
// Single-port line buffer: synchronous write, combinational read at the same address.
module scale_line_buf
  import scale_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 10,
  parameter int A_W   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [A_W-1:0]   addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/scale_down_box.sv
// Raster-stream down-scaler by F = 2^FACTOR_LOG2: rounded FxF box average or
// top-left decimation, with ask/display handshakes and output backpressure.
module scale_down_box
  import scale_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int PIX_W       = 8,
  parameter int FACTOR_LOG2 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [PIX_W-1:0] in,
  input  logic             in_valid,
  output logic             ask,
  output logic [PIX_W-1:0] out,
  output logic             display,
  input  logic             out_ready,
  output logic             frame_done
);

  localparam int F      = 1 << FACTOR_LOG2;
  localparam int HACC_W = PIX_W + FACTOR_LOG2;
  localparam int SUM_W  = sum_w(PIX_W, FACTOR_LOG2);
  localparam int DEPTH  = buf_depth(IMG_W, FACTOR_LOG2);
  localparam int X_W    = cnt_w(IMG_W);
  localparam int Y_W    = cnt_w(IMG_H);
  localparam int A_W    = cnt_w(DEPTH);

  // Round half up; the result cannot exceed the pixel range since S <= F*F*(2^PIX_W-1).
  function automatic logic [PIX_W-1:0] round_avg(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
    t = s + SUM_W'(1 << (2 * FACTOR_LOG2 - 1));
    return PIX_W'(t >> (2 * FACTOR_LOG2));
  endfunction

  logic              r_en;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  mode_t             r_mode;
  logic [HACC_W-1:0] r_hacc;

  logic              w_accept;
  logic              w_first;
  logic              w_x_start;
  logic              w_x_end;
  logic              w_y_start;
  logic              w_y_end;
  logic              w_x_last;
  mode_t             w_mode;
  logic [HACC_W-1:0] w_hsum;
  logic [A_W-1:0]    w_addr;
  logic [SUM_W-1:0]  w_rd;
  logic [SUM_W-1:0]  w_wr;
  logic              w_we;
  logic              w_load;
  logic              w_load_fd;
  logic [PIX_W-1:0]  w_res;

  assign ask       = r_en && !(display && !out_ready);
  assign w_accept  = ask && in_valid;
  assign w_x_start = (r_x[FACTOR_LOG2-1:0] == '0);
  assign w_x_end   = &r_x[FACTOR_LOG2-1:0];
  assign w_y_start = (r_y[FACTOR_LOG2-1:0] == '0);
  assign w_y_end   = &r_y[FACTOR_LOG2-1:0];
  assign w_x_last  = (r_x == X_W'(IMG_W - 1));
  assign w_first   = (r_x == '0) && (r_y == '0);
  // Pixel (0,0) already obeys the incoming mode, before it is latched.
  assign w_mode    = w_first ? mode_t'(mode) : r_mode;

  assign w_hsum = (w_x_start ? '0 : r_hacc) + HACC_W'(in);
  assign w_addr = A_W'(r_x >> FACTOR_LOG2);
  assign w_wr   = (w_y_start ? '0 : w_rd) + SUM_W'(w_hsum);
  assign w_we   = w_accept && (w_mode == MODE_AVG) && w_x_end;

  scale_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (SUM_W),
    .A_W   (A_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_wr),
    .rdata (w_rd)
  );

  always_comb begin
    w_load    = 1'b0;
    w_load_fd = 1'b0;
    w_res     = '0;
    if (w_accept) begin
      if (w_mode == MODE_AVG) begin
        w_load    = w_x_end && w_y_end;
        w_res     = round_avg(w_wr);
        w_load_fd = (r_x == X_W'(IMG_W - 1)) && (r_y == Y_W'(IMG_H - 1));
      end else begin
        w_load    = w_x_start && w_y_start;
        w_res     = in;
        w_load_fd = (r_x == X_W'(IMG_W - F)) && (r_y == Y_W'(IMG_H - F));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= MODE_AVG;
      r_hacc <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_accept) begin
        r_hacc <= w_hsum;
        if (w_first) r_mode <= mode_t'(mode);
        if (w_x_last) begin
          r_x <= '0;
          r_y <= (r_y == Y_W'(IMG_H - 1)) ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
    end
  end

  // Output register: a new result may load on the same edge the old one is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      display    <= 1'b0;
      frame_done <= 1'b0;
    end else if (w_load) begin
      out        <= w_res;
      display    <= 1'b1;
      frame_done <= w_load_fd;
    end else if (display && out_ready) begin
      display    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scale_down_box.sv
// Directed bench for scale_down_box: F=2 128x128 instance and F=4 16x16 instance.
module tb_scale_down_box;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       a_rst_n, a_mode, a_iv, a_or, a_ask, a_disp, a_fd;
  logic [7:0] a_in, a_out;
  logic       b_rst_n, b_mode, b_iv, b_or, b_ask, b_disp, b_fd;
  logic [7:0] b_in, b_out;

  scale_down_box #(.IMG_W(128), .IMG_H(128), .PIX_W(8), .FACTOR_LOG2(1)) u_a (
    .clk(clk), .reset(a_rst_n), .mode(a_mode), .in(a_in), .in_valid(a_iv),
    .ask(a_ask), .out(a_out), .display(a_disp), .out_ready(a_or), .frame_done(a_fd)
  );

  scale_down_box #(.IMG_W(16), .IMG_H(16), .PIX_W(8), .FACTOR_LOG2(2)) u_b (
    .clk(clk), .reset(b_rst_n), .mode(b_mode), .in(b_in), .in_valid(b_iv),
    .ask(b_ask), .out(b_out), .display(b_disp), .out_ready(b_or), .frame_done(b_fd)
  );

  int qa_out[$];
  bit qa_fd[$];
  int qb_out[$];
  bit qb_fd[$];

  // out_ready only changes just after a rising edge, so this sample matches the next edge.
  always @(negedge clk) begin
    if (a_disp && a_or) begin qa_out.push_back(int'(a_out)); qa_fd.push_back(a_fd); end
    if (b_disp && b_or) begin qb_out.push_back(int'(b_out)); qb_fd.push_back(b_fd); end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int kind, input int x, input int y);
    case (kind)
      0: return 100;
      1: begin
        if (y < 2 && x < 2) return 1 + x + 2 * y;
        if (y < 2 && x < 4) return 255;
        if (y < 2 && x < 6) return (x == 5 && y == 1) ? 2 : 0;
        return (x + 3 * y) & 255;
      end
      2: return (x + 3 * y) & 255;
      3: return (x * 7 + y * 13 + 5) & 255;
      default: return (x * 29 + y * 3 + 200) & 255;
    endcase
  endfunction

  function automatic int box_exp(input int kind, input int f, input int i, input int j);
    int s;
    s = 0;
    for (int dy = 0; dy < f; dy++)
      for (int dx = 0; dx < f; dx++)
        s += pix(kind, f * i + dx, f * j + dy);
    return (s + f * f / 2) / (f * f);
  endfunction

  task automatic drive(input bit sel, input int p, input bit m, input int gap);
    int  guard;
    bit  acc;
    repeat (gap) begin @(posedge clk); #1; end
    if (sel) begin b_in = 8'(p); b_mode = m; b_iv = 1'b1; end
    else     begin a_in = 8'(p); a_mode = m; a_iv = 1'b1; end
    guard = 0;
    forever begin
      @(negedge clk);
      acc = sel ? b_ask : a_ask;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 5000) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: pixel never accepted after %0d cycles, required acceptance", guard);
        $fatal(1, "accept timeout");
      end
    end
    if (sel) b_iv = 1'b0; else a_iv = 1'b0;
  endtask

  task automatic send_range(input bit sel, input int kind, input int w, input bit m0,
                            input int k0, input int k1, input int flip_at, input int maxgap);
    bit m;
    for (int k = k0; k < k1; k++) begin
      m = (k >= flip_at) ? !m0 : m0;
      drive(sel, pix(kind, k % w, k / w), m,
            (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic check_frame(input string tag, input bit sel, input int kind, input int f,
                             input int nbw, input int nbh, input bit dec);
    int q[$];
    bit fq[$];
    int bad, fdn, fdpos, e;
    repeat (3) begin @(posedge clk); #1; end
    if (sel) begin q = qb_out; fq = qb_fd; end
    else     begin q = qa_out; fq = qa_fd; end
    bad = 0; fdn = 0; fdpos = -1;
    for (int k = 0; k < q.size(); k++) begin
      e = dec ? pix(kind, f * (k % nbw), f * (k / nbw))
              : box_exp(kind, f, k % nbw, k / nbw);
      if (q[k] != e) begin
        if (bad == 0) $display("[TB] %s first bad output %0d: got %0d want %0d", tag, k, q[k], e);
        bad++;
      end
      if (fq[k]) begin fdn++; fdpos = k; end
    end
    check({tag, " output_count"}, q.size(), nbw * nbh);
    check({tag, " bad_outputs"}, bad, 0);
    check({tag, " frame_done_count"}, fdn, 1);
    check({tag, " frame_done_index"}, fdpos, nbw * nbh - 1);
  endtask

  int held;

  initial begin
    a_rst_n = 1'b0; a_mode = 1'b0; a_iv = 1'b0; a_or = 1'b1; a_in = '0;
    b_rst_n = 1'b0; b_mode = 1'b0; b_iv = 1'b0; b_or = 1'b1; b_in = '0;
    #1;
    check("rst out", int'(a_out), 0);
    check("rst display", int'(a_disp), 0);
    check("rst frame_done", int'(a_fd), 0);
    check("rst ask", int'(a_ask), 0);
    check("rst ask b", int'(b_ask), 0);
    #11;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    check("ask before first edge", int'(a_ask), 0);
    @(posedge clk); #1;
    check("ask after first edge", int'(a_ask), 1);

    // Frame A1: constant 100, box mode
    send_range(1'b0, 0, 128, 1'b0, 0, 16384, 1 << 30, 0);
    check_frame("const_box", 1'b0, 0, 2, 64, 64, 1'b0);
    qa_out.delete(); qa_fd.delete();

    // Frame A2: rounding blocks + ramp, with a 10-cycle stall after the first output
    send_range(1'b0, 1, 128, 1'b0, 0, 130, 1 << 30, 0);
    check("first avg out", int'(a_out), 3);
    check("first avg display", int'(a_disp), 1);
    held = int'(a_out);
    a_or = 1'b0;
    a_in = 8'(pix(1, 2, 1)); a_mode = 1'b0; a_iv = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall ask", int'(a_ask), 0);
      check("stall out", int'(a_out), held);
      check("stall display", int'(a_disp), 1);
      @(posedge clk); #1;
    end
    a_or = 1'b1;
    send_range(1'b0, 1, 128, 1'b0, 130, 16384, 1 << 30, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("round 1234", qa_out[0], 3);
    check("sat 255", qa_out[1], 255);
    check("round 0002", qa_out[2], 1);
    check_frame("round_stall", 1'b0, 1, 2, 64, 64, 1'b0);
    qa_out.delete(); qa_fd.delete();

    // Frame A3: decimate ramp, mode flips mid-frame; A4 then uses the new mode
    send_range(1'b0, 2, 128, 1'b1, 0, 16384, 5000, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("dec ramp (1,0)", qa_out[1], 2);
    check("dec ramp (0,1)", qa_out[64], 6);
    check("dec ramp (5,3)", qa_out[3 * 64 + 5], 28);
    check_frame("decimate", 1'b0, 2, 2, 64, 64, 1'b1);
    qa_out.delete(); qa_fd.delete();
    send_range(1'b0, 2, 128, 1'b0, 0, 16384, 1 << 30, 0);
    check_frame("next_frame_box", 1'b0, 2, 2, 64, 64, 1'b0);
    qa_out.delete(); qa_fd.delete();

    // F=4 instance: gapped frame, then reset mid-frame and a clean frame
    send_range(1'b1, 3, 16, 1'b0, 0, 256, 1 << 30, 3);
    check_frame("f4_gaps", 1'b1, 3, 4, 4, 4, 1'b0);
    qb_out.delete(); qb_fd.delete();
    send_range(1'b1, 4, 16, 1'b0, 0, 100, 1 << 30, 2);
    b_rst_n = 1'b0;
    #1;
    check("f4 reset display", int'(b_disp), 0);
    check("f4 reset out", int'(b_out), 0);
    check("f4 reset ask", int'(b_ask), 0);
    check("f4 outputs before reset", qb_out.size(), 4);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    qb_out.delete(); qb_fd.delete();
    send_range(1'b1, 4, 16, 1'b0, 0, 256, 1 << 30, 2);
    check_frame("f4_after_reset", 1'b1, 4, 4, 4, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
